// File: rtl/sched_pkg.sv
// Shared op encodings, instruction record and FSM state for the dual-issue scheduler.
package sched_pkg;

    localparam int REG_W = 4;
    localparam int OP_W  = 4;
    localparam int IME_W = 5;

    localparam logic [OP_W-1:0] OP_NOP      = 4'h0;
    localparam logic [OP_W-1:0] OP_ALU_LO   = 4'h1;
    localparam logic [OP_W-1:0] OP_ALU_HI   = 4'h7;
    localparam logic [OP_W-1:0] OP_ADDI     = 4'h8;
    localparam logic [OP_W-1:0] OP_LD       = 4'h9;
    localparam logic [OP_W-1:0] OP_ST       = 4'hA;
    localparam logic [OP_W-1:0] OP_BEQ      = 4'hB;
    localparam logic [OP_W-1:0] OP_NOP_HI   = 4'hC;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] des;
        logic [REG_W-1:0] s1;
        logic [REG_W-1:0] s2;
        logic [IME_W-1:0] ime;
    } dec_ins_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        PAIR   = 2'd1,
        SINGLE = 2'd2
    } state_t;

    // 0xC-0xF are reserved encodings and behave exactly like NOP.
    function automatic logic is_nop(input logic [OP_W-1:0] op);
        return (op == OP_NOP) || (op >= OP_NOP_HI);
    endfunction

    function automatic logic uses_s1(input logic [OP_W-1:0] op);
        return !is_nop(op);
    endfunction

    function automatic logic uses_s2(input logic [OP_W-1:0] op);
        return ((op >= OP_ALU_LO) && (op <= OP_ALU_HI)) || (op == OP_ST) || (op == OP_BEQ);
    endfunction

    function automatic logic writes_des(input logic [OP_W-1:0] op);
        return ((op >= OP_ALU_LO) && (op <= OP_ADDI)) || (op == OP_LD);
    endfunction

    function automatic logic is_mem(input logic [OP_W-1:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Decode, issue, writeback and statistics signals around the dual-issue scheduler.
interface dual_issue_scheduler_if
    import sched_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    // dec_valid/dec_ready: a pair transfers on a rising edge where both are high; dec_valid must
    // not wait on dec_ready. iss_ready is a grant: issue valids never assert without it.
    logic             flush;
    logic             dec_valid;
    logic             dec_ready;
    logic [OP_W-1:0]  ins_1_op;
    logic [REG_W-1:0] ins_1_des;
    logic [REG_W-1:0] ins_1_s1;
    logic [REG_W-1:0] ins_1_s2;
    logic [IME_W-1:0] ins_1_ime;
    logic [OP_W-1:0]  ins_2_op;
    logic [REG_W-1:0] ins_2_des;
    logic [REG_W-1:0] ins_2_s1;
    logic [REG_W-1:0] ins_2_s2;
    logic [IME_W-1:0] ins_2_ime;
    logic             iss_ready;
    logic             iss0_valid;
    logic [OP_W-1:0]  iss0_op;
    logic [REG_W-1:0] iss0_des;
    logic [REG_W-1:0] iss0_s1;
    logic [REG_W-1:0] iss0_s2;
    logic [IME_W-1:0] iss0_ime;
    logic             iss1_valid;
    logic [OP_W-1:0]  iss1_op;
    logic [REG_W-1:0] iss1_des;
    logic [REG_W-1:0] iss1_s1;
    logic [REG_W-1:0] iss1_s2;
    logic [IME_W-1:0] iss1_ime;
    logic             wb0_valid;
    logic [REG_W-1:0] wb0_des;
    logic             wb1_valid;
    logic [REG_W-1:0] wb1_des;
    logic [CNT_W-1:0] stat_stalls;
    logic [CNT_W-1:0] stat_dual;

    modport slave (
        input  flush, dec_valid,
        input  ins_1_op, ins_1_des, ins_1_s1, ins_1_s2, ins_1_ime,
        input  ins_2_op, ins_2_des, ins_2_s1, ins_2_s2, ins_2_ime,
        input  iss_ready, wb0_valid, wb0_des, wb1_valid, wb1_des,
        output dec_ready,
        output iss0_valid, iss0_op, iss0_des, iss0_s1, iss0_s2, iss0_ime,
        output iss1_valid, iss1_op, iss1_des, iss1_s1, iss1_s2, iss1_ime,
        output stat_stalls, stat_dual
    );

    modport master (
        output flush, dec_valid,
        output ins_1_op, ins_1_des, ins_1_s1, ins_1_s2, ins_1_ime,
        output ins_2_op, ins_2_des, ins_2_s1, ins_2_s2, ins_2_ime,
        output iss_ready, wb0_valid, wb0_des, wb1_valid, wb1_des,
        input  dec_ready,
        input  iss0_valid, iss0_op, iss0_des, iss0_s1, iss0_s2, iss0_ime,
        input  iss1_valid, iss1_op, iss1_des, iss1_s1, iss1_s2, iss1_ime,
        input  stat_stalls, stat_dual
    );

endinterface

// File: rtl/sched_scoreboard.sv
// Busy bit per architectural register: set when a writer issues, cleared on writeback.
module sched_scoreboard
    import sched_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_set0_valid,
    input  logic [REG_W-1:0]    i_set0_des,
    input  logic                i_set1_valid,
    input  logic [REG_W-1:0]    i_set1_des,
    input  logic                i_clr0_valid,
    input  logic [REG_W-1:0]    i_clr0_des,
    input  logic                i_clr1_valid,
    input  logic [REG_W-1:0]    i_clr1_des,
    output logic [NUM_REGS-1:0] o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_set0_valid) w_set[i_set0_des] = 1'b1;
        if (i_set1_valid) w_set[i_set1_des] = 1'b1;
        if (i_clr0_valid) w_clr[i_clr0_des] = 1'b1;
        if (i_clr1_valid) w_clr[i_clr1_des] = 1'b1;
    end

    // A set only happens on a non-busy register, where a coincident writeback is meaningless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_set | (r_busy & ~w_clr);
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order two-wide issue from a one-pair buffer, with RAW/WAW, scoreboard and memory-port checks.
module dual_issue_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dual_issue_scheduler_if.slave bus,
    output state_t                o_dbg_state,
    output logic [NUM_REGS-1:0]   o_dbg_busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    dec_ins_t            r_a;
    dec_ins_t            r_b;
    logic [CNT_W-1:0]    r_stalls;
    logic [CNT_W-1:0]    r_dual;
    logic [NUM_REGS-1:0] w_busy;
    dec_ins_t            w_ins_1;
    dec_ins_t            w_ins_2;
    dec_ins_t            w_old;
    logic                w_iss0;
    logic                w_iss1;
    logic                w_raw;
    logic                w_waw;
    logic                w_done;
    logic                w_accept;

    function automatic logic blocked(input dec_ins_t ins, input logic [NUM_REGS-1:0] busy);
        return (uses_s1(ins.op) && busy[ins.s1]) ||
               (uses_s2(ins.op) && busy[ins.s2]) ||
               (writes_des(ins.op) && busy[ins.des]);
    endfunction

    assign w_ins_1 = {bus.ins_1_op, bus.ins_1_des, bus.ins_1_s1, bus.ins_1_s2, bus.ins_1_ime};
    assign w_ins_2 = {bus.ins_2_op, bus.ins_2_des, bus.ins_2_s1, bus.ins_2_s2, bus.ins_2_ime};

    // In SINGLE the surviving younger entry has become the oldest.
    assign w_old = (r_state == PAIR) ? r_a : r_b;

    assign w_iss0 = bus.iss_ready && !bus.flush && (r_state != EMPTY) && !blocked(w_old, w_busy);

    assign w_raw = writes_des(r_a.op) &&
                   ((uses_s1(r_b.op) && (r_b.s1 == r_a.des)) ||
                    (uses_s2(r_b.op) && (r_b.s2 == r_a.des)));
    assign w_waw = writes_des(r_a.op) && writes_des(r_b.op) && (r_a.des == r_b.des);

    assign w_iss1 = w_iss0 && (r_state == PAIR) && !w_raw && !w_waw &&
                    !blocked(r_b, w_busy) && !(is_mem(r_a.op) && is_mem(r_b.op));

    assign w_done = (r_state == EMPTY) ||
                    ((r_state == PAIR) && w_iss1) ||
                    ((r_state == SINGLE) && w_iss0);

    assign bus.dec_ready = !bus.flush && w_done;
    assign w_accept      = bus.dec_valid && bus.dec_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_a     <= '0;
            r_b     <= '0;
        end else if (bus.flush) begin
            r_state <= EMPTY;
        end else if (w_accept) begin
            r_state <= PAIR;
            r_a     <= w_ins_1;
            r_b     <= w_ins_2;
        end else begin
            case (r_state)
                PAIR: begin
                    if (w_iss1)      r_state <= EMPTY;
                    else if (w_iss0) r_state <= SINGLE;
                end
                SINGLE: begin
                    if (w_iss0) r_state <= EMPTY;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stalls <= '0;
            r_dual   <= '0;
        end else begin
            if ((r_state != EMPTY) && !bus.flush && !w_iss0 && (r_stalls != '1))
                r_stalls <= r_stalls + CNT_ONE;
            if (w_iss1 && (r_dual != '1))
                r_dual <= r_dual + CNT_ONE;
        end
    end

    sched_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_set0_valid (w_iss0 && writes_des(w_old.op)),
        .i_set0_des   (w_old.des),
        .i_set1_valid (w_iss1 && writes_des(r_b.op)),
        .i_set1_des   (r_b.des),
        .i_clr0_valid (bus.wb0_valid),
        .i_clr0_des   (bus.wb0_des),
        .i_clr1_valid (bus.wb1_valid),
        .i_clr1_des   (bus.wb1_des),
        .o_busy       (w_busy)
    );

    assign bus.iss0_valid  = w_iss0;
    assign bus.iss0_op     = w_old.op;
    assign bus.iss0_des    = w_old.des;
    assign bus.iss0_s1     = w_old.s1;
    assign bus.iss0_s2     = w_old.s2;
    assign bus.iss0_ime    = w_old.ime;
    assign bus.iss1_valid  = w_iss1;
    assign bus.iss1_op     = r_b.op;
    assign bus.iss1_des    = r_b.des;
    assign bus.iss1_s1     = r_b.s1;
    assign bus.iss1_s2     = r_b.s2;
    assign bus.iss1_ime    = r_b.ime;
    assign bus.stat_stalls = r_stalls;
    assign bus.stat_dual   = r_dual;

    assign o_dbg_state = r_state;
    assign o_dbg_busy  = w_busy;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed scenarios plus a randomized run against an in-order issue model of the scheduler.
`timescale 1ns/1ps
module tb_dual_issue_scheduler;
    import sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    state_t      dbg_state;
    logic [15:0] dbg_busy;
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model: pending instructions oldest-first, busy set, statistics.
    logic [20:0] exp_q[$];
    logic [15:0] m_busy;
    logic [15:0] m_stalls;
    logic [15:0] m_dual;

    always #5 clk = ~clk;

    dual_issue_scheduler_if #(.CNT_W(16)) bus ();

    dual_issue_scheduler #(
        .NUM_REGS (16),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state),
        .o_dbg_busy  (dbg_busy)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [20:0] mk(input logic [3:0] op, input logic [3:0] des,
                                       input logic [3:0] s1, input logic [3:0] s2);
        return {op, des, s1, s2, 5'd0};
    endfunction

    function automatic bit m_src1(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'hB);
    endfunction
    function automatic bit m_src2(input logic [3:0] op);
        return ((op >= 4'h1) && (op <= 4'h7)) || (op == 4'hA) || (op == 4'hB);
    endfunction
    function automatic bit m_wr(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h9);
    endfunction
    function automatic bit m_mem(input logic [3:0] op);
        return (op == 4'h9) || (op == 4'hA);
    endfunction

    task automatic set_idle();
        bus.flush = 1'b0;
        bus.dec_valid = 1'b0;
        {bus.ins_1_op, bus.ins_1_des, bus.ins_1_s1, bus.ins_1_s2, bus.ins_1_ime} = '0;
        {bus.ins_2_op, bus.ins_2_des, bus.ins_2_s1, bus.ins_2_s2, bus.ins_2_ime} = '0;
        bus.iss_ready = 1'b1;
        bus.wb0_valid = 1'b0;
        bus.wb0_des = '0;
        bus.wb1_valid = 1'b0;
        bus.wb1_des = '0;
    endtask

    task automatic drive_pair(input logic [20:0] a, input logic [20:0] b);
        bus.dec_valid = 1'b1;
        {bus.ins_1_op, bus.ins_1_des, bus.ins_1_s1, bus.ins_1_s2, bus.ins_1_ime} = a;
        {bus.ins_2_op, bus.ins_2_des, bus.ins_2_s1, bus.ins_2_s2, bus.ins_2_ime} = b;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_busy = '0;
        m_stalls = '0;
        m_dual = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (dbg_state !== EMPTY) begin n_errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        n_checks++; if (bus.iss0_valid !== 1'b0) begin n_errors++; $display("FAIL reset_iss0: got %b want 0", bus.iss0_valid); end
        n_checks++; if (bus.iss1_valid !== 1'b0) begin n_errors++; $display("FAIL reset_iss1: got %b want 0", bus.iss1_valid); end
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", bus.dec_ready); end
        n_checks++; if (bus.stat_stalls !== 16'd0) begin n_errors++; $display("FAIL reset_stalls: got %0d want 0", bus.stat_stalls); end
        n_checks++; if (bus.stat_dual !== 16'd0) begin n_errors++; $display("FAIL reset_dual: got %0d want 0", bus.stat_dual); end
        n_checks++; if (dbg_busy !== 16'h0000) begin n_errors++; $display("FAIL reset_busy: got %h want 0000", dbg_busy); end
    endtask

    task automatic test_independent();
        apply_reset();
        drive_pair(mk(4'h1, 4'd1, 4'd2, 4'd3), mk(4'h2, 4'd4, 4'd5, 4'd6));
        #1;
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_errors++; $display("FAIL indep_ready: got %b want 1", bus.dec_ready); end
        next_cycle();
        set_idle();
        #1;
        n_checks++; if (bus.iss0_valid !== 1'b1) begin n_errors++; $display("FAIL indep_iss0: got %b want 1", bus.iss0_valid); end
        n_checks++; if (bus.iss1_valid !== 1'b1) begin n_errors++; $display("FAIL indep_iss1: got %b want 1", bus.iss1_valid); end
        n_checks++; if (bus.iss0_des !== 4'd1) begin n_errors++; $display("FAIL indep_iss0_des: got %0d want 1", bus.iss0_des); end
        n_checks++; if (bus.iss1_des !== 4'd4) begin n_errors++; $display("FAIL indep_iss1_des: got %0d want 4", bus.iss1_des); end
        next_cycle();
        #1;
        n_checks++; if (dbg_busy !== 16'h0012) begin n_errors++; $display("FAIL indep_busy: got %h want 0012", dbg_busy); end
        n_checks++; if (bus.stat_dual !== 16'd1) begin n_errors++; $display("FAIL indep_dual: got %0d want 1", bus.stat_dual); end
        n_checks++; if (dbg_state !== EMPTY) begin n_errors++; $display("FAIL indep_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_intra_raw();
        apply_reset();
        drive_pair(mk(4'h1, 4'd1, 4'd2, 4'd3), mk(4'h1, 4'd4, 4'd1, 4'd5));
        next_cycle();
        set_idle();
        #1;
        n_checks++; if (bus.iss0_valid !== 1'b1) begin n_errors++; $display("FAIL raw_c1_iss0: got %b want 1", bus.iss0_valid); end
        n_checks++; if (bus.iss1_valid !== 1'b0) begin n_errors++; $display("FAIL raw_c1_iss1: got %b want 0", bus.iss1_valid); end
        n_checks++; if (bus.dec_ready !== 1'b0) begin n_errors++; $display("FAIL raw_c1_ready: got %b want 0", bus.dec_ready); end
        next_cycle();
        bus.wb0_valid = 1'b1;
        bus.wb0_des = 4'd1;
        #1;
        n_checks++; if (dbg_state !== SINGLE) begin n_errors++; $display("FAIL raw_c2_state: got %0d want 2", dbg_state); end
        n_checks++; if (bus.iss0_valid !== 1'b0) begin n_errors++; $display("FAIL raw_c2_nobypass: got %b want 0", bus.iss0_valid); end
        next_cycle();
        bus.wb0_valid = 1'b0;
        #1;
        n_checks++; if (bus.iss0_valid !== 1'b1) begin n_errors++; $display("FAIL raw_c3_iss0: got %b want 1", bus.iss0_valid); end
        n_checks++; if (bus.iss0_des !== 4'd4) begin n_errors++; $display("FAIL raw_c3_des: got %0d want 4", bus.iss0_des); end
        n_checks++; if (bus.iss1_valid !== 1'b0) begin n_errors++; $display("FAIL raw_c3_iss1: got %b want 0", bus.iss1_valid); end
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_errors++; $display("FAIL raw_c3_ready: got %b want 1", bus.dec_ready); end
        next_cycle();
        #1;
        n_checks++; if (dbg_busy !== 16'h0010) begin n_errors++; $display("FAIL raw_busy: got %h want 0010", dbg_busy); end
        n_checks++; if (bus.stat_stalls !== 16'd1) begin n_errors++; $display("FAIL raw_stalls: got %0d want 1", bus.stat_stalls); end
    endtask

    task automatic test_sb_stall();
        apply_reset();
        drive_pair(mk(4'h8, 4'd7, 4'd0, 4'd0), mk(4'h0, 4'd0, 4'd0, 4'd0));
        next_cycle();
        drive_pair(mk(4'h9, 4'd8, 4'd7, 4'd0), mk(4'h0, 4'd0, 4'd0, 4'd0));
        #1;
        n_checks++; if (bus.iss1_valid !== 1'b1) begin n_errors++; $display("FAIL stall_setup_dual: got %b want 1", bus.iss1_valid); end
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_errors++; $display("FAIL stall_setup_ready: got %b want 1", bus.dec_ready); end
        next_cycle();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.iss0_valid !== 1'b0) begin n_errors++; $display("FAIL stall_iss0[%0d]: got %b want 0", i, bus.iss0_valid); end
            n_checks++; if (bus.stat_stalls !== 16'(i)) begin n_errors++; $display("FAIL stall_count[%0d]: got %0d want %0d", i, bus.stat_stalls, i); end
            next_cycle();
        end
        bus.wb0_valid = 1'b1;
        bus.wb0_des = 4'd7;
        #1;
        n_checks++; if (bus.iss0_valid !== 1'b0) begin n_errors++; $display("FAIL stall_wb_cycle: got %b want 0", bus.iss0_valid); end
        next_cycle();
        set_idle();
        #1;
        n_checks++; if (bus.iss0_valid !== 1'b1) begin n_errors++; $display("FAIL stall_release_iss0: got %b want 1", bus.iss0_valid); end
        n_checks++; if (bus.iss1_valid !== 1'b1) begin n_errors++; $display("FAIL stall_release_iss1: got %b want 1", bus.iss1_valid); end
        n_checks++; if (bus.iss0_op !== 4'h9) begin n_errors++; $display("FAIL stall_release_op: got %h want 9", bus.iss0_op); end
        n_checks++; if (bus.stat_stalls !== 16'd4) begin n_errors++; $display("FAIL stall_total: got %0d want 4", bus.stat_stalls); end
        next_cycle();
        #1;
        n_checks++; if (bus.stat_dual !== 16'd2) begin n_errors++; $display("FAIL stall_dual: got %0d want 2", bus.stat_dual); end
        n_checks++; if (dbg_busy !== 16'h0100) begin n_errors++; $display("FAIL stall_busy: got %h want 0100", dbg_busy); end
    endtask

    task automatic test_two_mem();
        apply_reset();
        drive_pair(mk(4'h9, 4'd1, 4'd2, 4'd0), mk(4'hA, 4'd0, 4'd3, 4'd4));
        next_cycle();
        set_idle();
        #1;
        n_checks++; if (bus.iss0_valid !== 1'b1) begin n_errors++; $display("FAIL mem_c1_iss0: got %b want 1", bus.iss0_valid); end
        n_checks++; if (bus.iss0_op !== 4'h9) begin n_errors++; $display("FAIL mem_c1_op: got %h want 9", bus.iss0_op); end
        n_checks++; if (bus.iss1_valid !== 1'b0) begin n_errors++; $display("FAIL mem_c1_iss1: got %b want 0", bus.iss1_valid); end
        next_cycle();
        #1;
        n_checks++; if (dbg_state !== SINGLE) begin n_errors++; $display("FAIL mem_c2_state: got %0d want 2", dbg_state); end
        n_checks++; if (bus.iss0_valid !== 1'b1) begin n_errors++; $display("FAIL mem_c2_iss0: got %b want 1", bus.iss0_valid); end
        n_checks++; if (bus.iss0_op !== 4'hA) begin n_errors++; $display("FAIL mem_c2_op: got %h want a", bus.iss0_op); end
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_errors++; $display("FAIL mem_c2_ready: got %b want 1", bus.dec_ready); end
        next_cycle();
        #1;
        n_checks++; if (dbg_busy !== 16'h0002) begin n_errors++; $display("FAIL mem_busy: got %h want 0002", dbg_busy); end
    endtask

    task automatic test_flush();
        apply_reset();
        drive_pair(mk(4'h1, 4'd1, 4'd2, 4'd3), mk(4'h1, 4'd4, 4'd1, 4'd5));
        next_cycle();
        set_idle();
        next_cycle();
        bus.flush = 1'b1;
        drive_pair(mk(4'h1, 4'd9, 4'd9, 4'd9), mk(4'h1, 4'd10, 4'd9, 4'd9));
        #1;
        n_checks++; if (dbg_state !== SINGLE) begin n_errors++; $display("FAIL flush_pre_state: got %0d want 2", dbg_state); end
        n_checks++; if (bus.iss0_valid !== 1'b0) begin n_errors++; $display("FAIL flush_iss0: got %b want 0", bus.iss0_valid); end
        n_checks++; if (bus.dec_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b want 0", bus.dec_ready); end
        next_cycle();
        set_idle();
        #1;
        n_checks++; if (dbg_state !== EMPTY) begin n_errors++; $display("FAIL flush_state: got %0d want 0", dbg_state); end
        n_checks++; if (bus.iss0_valid !== 1'b0) begin n_errors++; $display("FAIL flush_post_iss0: got %b want 0", bus.iss0_valid); end
        n_checks++; if (dbg_busy !== 16'h0002) begin n_errors++; $display("FAIL flush_busy: got %h want 0002", dbg_busy); end
        n_checks++; if (bus.dec_ready !== 1'b1) begin n_errors++; $display("FAIL flush_post_ready: got %b want 1", bus.dec_ready); end
        n_checks++; if (bus.stat_stalls !== 16'd0) begin n_errors++; $display("FAIL flush_stalls: got %0d want 0", bus.stat_stalls); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive_pair(mk(4'h1, 4'd1, 4'd2, 4'd3), mk(4'h2, 4'd4, 4'd5, 4'd6));
        next_cycle();
        drive_pair(mk(4'h1, 4'd6, 4'd1, 4'd2), mk(4'h0, 4'd0, 4'd0, 4'd0));
        next_cycle();
        set_idle();
        #1;
        n_checks++; if (dbg_state !== PAIR) begin n_errors++; $display("FAIL arst_pre_state: got %0d want 1", dbg_state); end
        n_checks++; if (dbg_busy !== 16'h0012) begin n_errors++; $display("FAIL arst_pre_busy: got %h want 0012", dbg_busy); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (dbg_state !== EMPTY) begin n_errors++; $display("FAIL arst_state: got %0d want 0", dbg_state); end
        n_checks++; if (dbg_busy !== 16'h0000) begin n_errors++; $display("FAIL arst_busy: got %h want 0000", dbg_busy); end
        n_checks++; if (bus.stat_dual !== 16'd0) begin n_errors++; $display("FAIL arst_dual: got %0d want 0", bus.stat_dual); end
        n_checks++; if (bus.stat_stalls !== 16'd0) begin n_errors++; $display("FAIL arst_stalls: got %0d want 0", bus.stat_stalls); end
        n_checks++; if ((bus.iss0_valid | bus.iss1_valid) !== 1'b0) begin n_errors++; $display("FAIL arst_valids: got %b%b want 00", bus.iss0_valid, bus.iss1_valid); end
        apply_reset();
    endtask

    task automatic test_random();
        logic [20:0] a;
        logic [20:0] b;
        logic [20:0] ins;
        logic [15:0] wr;
        logic [15:0] setm;
        logic [15:0] clrm;
        logic [3:0]  op;
        int          k;
        int          n;
        bit          mem_used;
        bit          stop;
        bit          ok;
        bit          e_ready;
        state_t      e_state;
        apply_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            a = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            b = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            drive_pair(a, b);
            bus.dec_valid = ($urandom_range(0, 9) < 6);
            bus.flush = ($urandom_range(0, 31) == 0);
            bus.iss_ready = ($urandom_range(0, 9) < 8);
            bus.wb0_valid = ($urandom_range(0, 9) < 4);
            bus.wb0_des = 4'($urandom_range(0, 7));
            bus.wb1_valid = ($urandom_range(0, 9) < 3);
            bus.wb1_des = 4'($urandom_range(0, 7));
            #1;
            // Issue in program order until the first instruction that cannot go.
            n = exp_q.size();
            k = 0; wr = '0; mem_used = 0; stop = 0;
            if (!bus.flush && bus.iss_ready) begin
                for (int i = 0; i < n; i++) begin
                    if (!stop) begin
                        ins = exp_q[i];
                        op = ins[20:17];
                        ok = 1;
                        if (m_src1(op) && (m_busy[ins[12:9]] || wr[ins[12:9]])) ok = 0;
                        if (m_src2(op) && (m_busy[ins[8:5]] || wr[ins[8:5]])) ok = 0;
                        if (m_wr(op) && (m_busy[ins[16:13]] || wr[ins[16:13]])) ok = 0;
                        if (m_mem(op) && mem_used) ok = 0;
                        if (ok) begin
                            k++;
                            if (m_wr(op)) wr[ins[16:13]] = 1'b1;
                            if (m_mem(op)) mem_used = 1;
                        end else begin
                            stop = 1;
                        end
                    end
                end
            end
            e_ready = !bus.flush && (k == n);
            e_state = (n == 0) ? EMPTY : ((n == 2) ? PAIR : SINGLE);
            n_checks++; if (dbg_state !== e_state) begin n_errors++; $display("FAIL rnd_state@%0d: got %0d want %0d", cyc, dbg_state, e_state); end
            n_checks++; if (bus.iss0_valid !== (k >= 1)) begin n_errors++; $display("FAIL rnd_iss0@%0d: got %b want %b", cyc, bus.iss0_valid, k >= 1); end
            n_checks++; if (bus.iss1_valid !== (k >= 2)) begin n_errors++; $display("FAIL rnd_iss1@%0d: got %b want %b", cyc, bus.iss1_valid, k >= 2); end
            n_checks++; if (bus.dec_ready !== e_ready) begin n_errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, bus.dec_ready, e_ready); end
            n_checks++; if (dbg_busy !== m_busy) begin n_errors++; $display("FAIL rnd_busy@%0d: got %h want %h", cyc, dbg_busy, m_busy); end
            n_checks++; if (bus.stat_stalls !== m_stalls) begin n_errors++; $display("FAIL rnd_stalls@%0d: got %0d want %0d", cyc, bus.stat_stalls, m_stalls); end
            n_checks++; if (bus.stat_dual !== m_dual) begin n_errors++; $display("FAIL rnd_dual@%0d: got %0d want %0d", cyc, bus.stat_dual, m_dual); end
            if (k >= 1) begin
                n_checks++;
                if ({bus.iss0_op, bus.iss0_des, bus.iss0_s1, bus.iss0_s2, bus.iss0_ime} !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL rnd_iss0_fields@%0d: got %h want %h", cyc,
                             {bus.iss0_op, bus.iss0_des, bus.iss0_s1, bus.iss0_s2, bus.iss0_ime}, exp_q[0]);
                end
            end
            if (k >= 2) begin
                n_checks++;
                if ({bus.iss1_op, bus.iss1_des, bus.iss1_s1, bus.iss1_s2, bus.iss1_ime} !== exp_q[1]) begin
                    n_errors++;
                    $display("FAIL rnd_iss1_fields@%0d: got %h want %h", cyc,
                             {bus.iss1_op, bus.iss1_des, bus.iss1_s1, bus.iss1_s2, bus.iss1_ime}, exp_q[1]);
                end
            end
            // Advance the model to the state after the coming clock edge.
            setm = '0; clrm = '0;
            for (int i = 0; i < k; i++) if (m_wr(exp_q[i][20:17])) setm[exp_q[i][16:13]] = 1'b1;
            if (bus.wb0_valid) clrm[bus.wb0_des] = 1'b1;
            if (bus.wb1_valid) clrm[bus.wb1_des] = 1'b1;
            m_busy = setm | (m_busy & ~clrm);
            if ((n > 0) && !bus.flush && (k == 0) && (m_stalls != 16'hFFFF)) m_stalls = m_stalls + 16'd1;
            if ((k == 2) && (m_dual != 16'hFFFF)) m_dual = m_dual + 16'd1;
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                for (int i = 0; i < k; i++) void'(exp_q.pop_front());
                if (bus.dec_valid && e_ready) begin
                    exp_q.push_back(a);
                    exp_q.push_back(b);
                end
            end
            next_cycle();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_independent();
        test_intra_raw();
        test_sb_stall();
        test_two_mem();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
